bp_adc_sampler: RTL and testbench
=================================

Name: bp_adc_sampler

Overview:
- Serial-ADC front end driven by the Bus Pirate command state machine when it executes CMD_ADC_READ.
- Selects the analog mux channel, lets the mux settle, then runs one CS-framed 16-clock SPI read of an ADCxx1S-style converter.
- Returns the right-justified sample to the state machine, which pushes it into the output FIFO.
- Sits between the command sequencer (upstream) and the adc_mux_en/adc_mux_s/adc_cs/adc_clock/adc_data board pins (downstream).

Parameters:
DATA_BITS, 12, converter resolution; result width.
LEAD_BITS, 3, leading zero bits preceding the MSB in the frame.
FRAME_CLKS, 16, SCLK cycles per CS frame; must be >= LEAD_BITS+DATA_BITS.
MUX_SETTLE, 8, clk cycles of mux settling before CS falls (>=1).
MUX_BITS, 4, mux select width.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; accepted only in IDLE
mux_sel  input  MUX_BITS  channel, latched at accept
clk_div  input  3  SCLK divider from ADC config register (bits 2:0), latched at accept
busy  output  1  high from accept until DONE completes
done  output  1  one-cycle pulse when result is valid
result  output  DATA_BITS  last conversion; holds until next done
adc_mux_en  output  1  analog mux enable
adc_mux_s  output  MUX_BITS  analog mux select
adc_cs  output  1  converter chip select, active low
adc_clock  output  1  converter SCLK, idles high
adc_data  input  1  converter serial data (MSB first)

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, result=0, adc_mux_en=0, adc_mux_s=0, adc_cs=1, adc_clock=1; all counters 0.
- H = clk_div+1 clk cycles, the SCLK half-period (1..8). It is latched at accept, so later clk_div changes affect only the next conversion.
- IDLE -> SETTLE on start=1:
  - Latch mux_sel to adc_mux_s and latch H.
  - Set adc_mux_en=1 and busy=1.
  - start while busy is ignored; no queueing.
- SETTLE: MUX_SETTLE cycles, then -> CS_SETUP.
- CS_SETUP: adc_cs=0 for H cycles, then -> SHIFT.
- SHIFT: FRAME_CLKS SCLK periods, each an H-cycle low half followed by an H-cycle high half.
  - adc_data is sampled on the clk edge that drives adc_clock 0->1.
  - Rising edges are numbered 1..FRAME_CLKS.
  - Edges LEAD_BITS+1 .. LEAD_BITS+DATA_BITS shift into a DATA_BITS register MSB first. All other edges are discarded.
  - After the last high half -> CS_HOLD, with adc_clock left high.
- CS_HOLD: adc_cs=1 for H cycles, then -> DONE.
- DONE: one cycle.
  - done=1 and result updated (same cycle).
  - adc_mux_en=0 and busy=0 from the next cycle; return to IDLE.
  - adc_mux_s keeps the last channel.
- Latency: done is high in the cycle MUX_SETTLE + (2*FRAME_CLKS+2)*H + 1 cycles after the accepting edge.
- Back-to-back: start in the cycle immediately after done is accepted (IDLE reached).
- Reset mid-conversion: immediate return to reset values; no done pulse; result is cleared.
- Counter widths must cover 2*FRAME_CLKS half-periods and H up to 8 without wrap.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro BP_ADC_AVERAGE_EN.
- When defined:
  - One accept runs 4 full CS frames. Each frame is CS_SETUP/SHIFT/CS_HOLD; SETTLE runs only once, before the first frame.
  - Samples accumulate in a DATA_BITS+2 register; result = accumulator >> 2 (truncated).
  - done pulses once, after the 4th CS_HOLD; adc_mux_en stays high throughout.
  - Latency becomes MUX_SETTLE + 4*(2*FRAME_CLKS+2)*H + 1.
- When undefined: single-frame behaviour above; no accumulator is synthesized.

Test Plan:
- Reset, no start -> adc_cs=1, adc_clock=1, adc_mux_en=0, busy=0, result=0 for 50 cycles.
- start, mux_sel=4'h1, clk_div=3 (H=4), adc_data=1 constantly -> adc_mux_en=1 and adc_mux_s=1 next cycle; CS low after 8 cycles; 16 SCLK periods of 8 cycles each; done exactly 8+34*4+1=145 cycles after accept; result=12'hFFF.
- Model converter driving 3 zeros then 12'hA5C MSB first, changing on SCLK falling edges, clk_div=0 -> result=12'hA5C; done 8+34+1=43 cycles after accept.
- start pulses during busy plus a clk_div change mid-SHIFT -> single conversion only; SCLK half-period unchanged; exactly one done.
- Assert rst during SHIFT -> adc_cs=1, adc_clock=1, adc_mux_en=0, busy=0 asynchronously; no done pulse; the next start completes normally.
- With BP_ADC_AVERAGE_EN, model returning 12'h100, 12'h101, 12'h102, 12'h103 in successive frames -> 4 CS frames, one done, result=12'h101.

Source files
------------

// File: rtl/bp_adc_sampler.sv
// bp_adc_sampler: serial-ADC front end for the Bus Pirate CMD_ADC_READ path.
// It selects the analog mux channel and waits for the mux to settle. It then
// runs one CS-framed SPI read of an ADCxx1S-style converter and returns the
// right-justified sample.
// Optional build macro BP_ADC_AVERAGE_EN: each request runs four CS frames
// and returns the truncated mean of the four samples.
module bp_adc_sampler #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_BITS  = 3,
  parameter int FRAME_CLKS = 16,
  parameter int MUX_SETTLE = 8,
  parameter int MUX_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MUX_BITS-1:0]  mux_sel,
  input  logic [2:0]           clk_div,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] result,
  output logic                 adc_mux_en,
  output logic [MUX_BITS-1:0]  adc_mux_s,
  output logic                 adc_cs,
  output logic                 adc_clock,
  input  logic                 adc_data
);

  // One shared cycle counter serves the settle wait and every H-cycle phase.
  localparam int CNT_MAX = (MUX_SETTLE > 8) ? MUX_SETTLE : 8;
  localparam int CW      = $clog2(CNT_MAX);
  // Half-period index inside a frame: 0 .. 2*FRAME_CLKS-1.
  localparam int HW      = $clog2(2 * FRAME_CLKS);

  // S_LATCH is the cycle after CS_HOLD in which the result is captured;
  // S_DONE is the cycle in which done is visible.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [HW-1:0]          half_q;
  logic [2:0]             hm1_q;      // latched H-1 (clk_div)
  logic [DATA_BITS-1:0]   shift_q;
  logic                   busy_q;
  logic                   done_q;
  logic [DATA_BITS-1:0]   result_q;
  logic                   mux_en_q;
  logic [MUX_BITS-1:0]    mux_s_q;
  logic                   cs_q;
  logic                   sclk_q;

`ifdef BP_ADC_AVERAGE_EN
  logic [1:0]             frame_q;
  logic [DATA_BITS+1:0]   acc_q;
`endif

  logic                   settle_hit;
  logic                   h_hit;
  logic                   keep_bit;
  logic                   last_half;
  logic [HW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   result_d;

  assign settle_hit = (cnt_q == CW'(MUX_SETTLE - 1));
  assign h_hit      = (cnt_q == CW'(hm1_q));
  assign bit_idx    = half_q >> 1;
  // Rising edge k (1-based) has bit_idx k-1; only the data window is kept.
  assign keep_bit   = (bit_idx >= HW'(LEAD_BITS)) &&
                      (bit_idx <  HW'(LEAD_BITS + DATA_BITS));
  assign last_half  = (half_q == HW'(2 * FRAME_CLKS - 1));

`ifdef BP_ADC_AVERAGE_EN
  assign result_d = acc_q[DATA_BITS+1:2];
`else
  assign result_d = shift_q;
`endif

  // Conversion sequencer: settle, CS setup, SCLK shifting, CS hold, result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      hm1_q    <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mux_en_q <= 1'b0;
      mux_s_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
`ifdef BP_ADC_AVERAGE_EN
      frame_q  <= '0;
      acc_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_SETTLE;
            mux_s_q  <= mux_sel;
            hm1_q    <= clk_div;
            mux_en_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
`ifdef BP_ADC_AVERAGE_EN
            frame_q  <= '0;
            acc_q    <= '0;
`endif
          end
        end
        S_SETTLE: begin
          if (settle_hit) begin
            state_q <= S_CS_SETUP;
            cs_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CS_SETUP: begin
          if (h_hit) begin
            state_q <= S_SHIFT;
            sclk_q  <= 1'b0;
            half_q  <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (h_hit) begin
            cnt_q <= '0;
            if (!half_q[0]) begin
              // End of a low half: SCLK rises and the data pin is sampled.
              sclk_q <= 1'b1;
              half_q <= half_q + 1'b1;
              if (keep_bit) begin
                shift_q <= {shift_q[DATA_BITS-2:0], adc_data};
              end
            end else if (last_half) begin
              // SCLK stays high into CS_HOLD.
              state_q <= S_CS_HOLD;
              cs_q    <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              half_q <= half_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CS_HOLD: begin
          if (h_hit) begin
            cnt_q <= '0;
`ifdef BP_ADC_AVERAGE_EN
            acc_q   <= acc_q + {2'b00, shift_q};
            frame_q <= frame_q + 1'b1;
            if (frame_q == 2'd3) begin
              state_q <= S_LATCH;
            end else begin
              state_q <= S_CS_SETUP;
              cs_q    <= 1'b0;
            end
`else
            state_q <= S_LATCH;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LATCH: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          result_q <= result_d;
        end
        S_DONE: begin
          // Channel select is left on the last channel.
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mux_en_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign adc_mux_en = mux_en_q;
  assign adc_mux_s  = mux_s_q;
  assign adc_cs     = cs_q;
  assign adc_clock  = sclk_q;

endmodule

// File: tb/tb_bp_adc_sampler.sv
// Self-checking bench for bp_adc_sampler: vector table plus directed
// sequences for ignored starts, reset mid-frame and (optionally) averaging.
module tb_bp_adc_sampler;

  localparam int MUX_SETTLE = 8;
  localparam int FRAME_CLKS = 16;
`ifdef BP_ADC_AVERAGE_EN
  localparam int NF = 4;
`else
  localparam int NF = 1;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  mux_sel;
  logic [2:0]  clk_div;
  logic        busy;
  logic        done;
  logic [11:0] result;
  logic        adc_mux_en;
  logic [3:0]  adc_mux_s;
  logic        adc_cs;
  logic        adc_clock;
  logic        adc_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Converter frame words per CS frame: {lead zeros, sample, trailing bit}
  logic [15:0] fr [4];

  bp_adc_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux_sel    (mux_sel),
    .clk_div    (clk_div),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .adc_mux_en (adc_mux_en),
    .adc_mux_s  (adc_mux_s),
    .adc_cs     (adc_cs),
    .adc_clock  (adc_clock),
    .adc_data   (adc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: first bit on CS fall, next bit on every SCLK fall.
  logic        m_cs_prev = 1'b1;
  logic        m_sclk_prev = 1'b1;
  logic        m_en_prev = 1'b0;
  int          m_fidx = 0;
  int          m_bidx = 0;
  logic [15:0] m_cur = 16'h0;
  always @(adc_cs or adc_clock or adc_mux_en) begin
    if (adc_mux_en === 1'b1 && m_en_prev !== 1'b1) m_fidx = 0;
    if (adc_cs === 1'b0 && m_cs_prev === 1'b1) begin
      m_cur    = fr[m_fidx & 3];
      m_fidx   = m_fidx + 1;
      m_bidx   = 0;
      adc_data = m_cur[15];
    end else if (adc_clock === 1'b0 && m_sclk_prev === 1'b1 && adc_cs === 1'b0) begin
      if (m_bidx < 16) adc_data = m_cur[15 - m_bidx];
      m_bidx = m_bidx + 1;
    end
    m_cs_prev   = adc_cs;
    m_sclk_prev = adc_clock;
    m_en_prev   = adc_mux_en;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One conversion. Caller is at a negedge; start is raised immediately.
  task automatic run_conv(input string nm, input logic [3:0] ms,
                          input logic [2:0] div, input bit inj,
                          input logic [11:0] exp_res);
    int h, exp_lat, k, lat, cs_first, rises, csf, lo_run, lo_min, lo_max;
    logic prev_sclk, prev_cs;
    logic [11:0] res;
    h       = int'(div) + 1;
    exp_lat = MUX_SETTLE + NF * (2 * FRAME_CLKS + 2) * h + 1;
    mux_sel = ms;
    clk_div = div;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_acc_busy"}, int'(busy), 1);
    chk({nm, "_acc_mux_en"}, int'(adc_mux_en), 1);
    chk({nm, "_acc_mux_s"}, int'(adc_mux_s), int'(ms));
    k = 0; lat = -1; cs_first = -1; rises = 0; csf = 0;
    lo_run = 0; lo_min = 999; lo_max = 0; res = 12'h0;
    prev_sclk = adc_clock;
    prev_cs   = adc_cs;
    while (lat < 0 && k < 4000) begin
      @(negedge clk);
      k++;
      if (!adc_cs && cs_first < 0) cs_first = k;
      if (prev_cs && !adc_cs) csf++;
      if (!prev_sclk && adc_clock) rises++;
      if (!adc_clock) lo_run++;
      else if (lo_run > 0) begin
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        lo_run = 0;
      end
      prev_sclk = adc_clock;
      prev_cs   = adc_cs;
      if (done) begin
        lat = k;
        res = result;
      end
      if (inj) begin
        if (k == 4) begin start = 1'b1; mux_sel = ~ms; end
        else if (k == 5) begin start = 1'b0; mux_sel = ms; end
        else if (k == MUX_SETTLE + h + 6) begin start = 1'b1; clk_div = ~div; end
        else if (k == MUX_SETTLE + h + 7) start = 1'b0;
      end
    end
    start   = 1'b0;
    mux_sel = ms;
    clk_div = div;
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"}, int'(res), int'(exp_res));
    chk({nm, "_cs_fall_cycle"}, cs_first, MUX_SETTLE);
    chk({nm, "_sclk_rises"}, rises, FRAME_CLKS * NF);
    chk({nm, "_cs_frames"}, csf, NF);
    chk({nm, "_sclk_low_min"}, lo_min, h);
    chk({nm, "_sclk_low_max"}, lo_max, h);
    chk({nm, "_mux_s_done"}, int'(adc_mux_s), int'(ms));
    @(negedge clk);
    chk({nm, "_post_done"}, int'(done), 0);
    chk({nm, "_post_busy"}, int'(busy), 0);
    chk({nm, "_post_mux_en"}, int'(adc_mux_en), 0);
    chk({nm, "_post_mux_s"}, int'(adc_mux_s), int'(ms));
    chk({nm, "_post_result"}, int'(result), int'(exp_res));
    $display("[TB] conv %s mux=%h div=%0d result=%h latency=%0d", nm, ms, div, res, lat);
  endtask

  typedef struct {
    logic [3:0]  ms;
    logic [2:0]  div;
    logic [15:0] frame;
    logic [11:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int bad_cs, bad_sclk, bad_en, bad_busy, bad_res, bad_done, dn;
    rst = 1'b0; start = 1'b0; mux_sel = 4'h0; clk_div = 3'd0;
    for (int i = 0; i < 4; i++) fr[i] = 16'h0;

    vecs[0] = '{4'h1, 3'd3, 16'hFFFF, 12'hFFF};  // constant high, H=4
    vecs[1] = '{4'h2, 3'd0, 16'h14B8, 12'hA5C};  // 000 A5C 0, H=1
    vecs[2] = '{4'hF, 3'd7, 16'h0002, 12'h001};  // LSB only, H=8
    vecs[3] = '{4'h0, 3'd1, 16'h1000, 12'h800};  // MSB only, H=2
    vecs[4] = '{4'h6, 3'd0, 16'hE001, 12'h000};  // ones outside window discarded
    vecs[5] = '{4'h9, 3'd2, 16'h0FFE, 12'h7FF};  // H=3

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset with no start.
    bad_cs = 0; bad_sclk = 0; bad_en = 0; bad_busy = 0; bad_res = 0; bad_done = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (adc_cs !== 1'b1) bad_cs++;
      if (adc_clock !== 1'b1) bad_sclk++;
      if (adc_mux_en !== 1'b0) bad_en++;
      if (busy !== 1'b0) bad_busy++;
      if (result !== 12'h0) bad_res++;
      if (done !== 1'b0) bad_done++;
    end
    chk("idle_cs_bad_cycles", bad_cs, 0);
    chk("idle_sclk_bad_cycles", bad_sclk, 0);
    chk("idle_mux_en_bad_cycles", bad_en, 0);
    chk("idle_busy_bad_cycles", bad_busy, 0);
    chk("idle_result_bad_cycles", bad_res, 0);
    chk("idle_done_bad_cycles", bad_done, 0);
    chk("idle_mux_s", int'(adc_mux_s), 0);

    // Table vectors, issued back to back.
    for (int i = 0; i < 6; i++) begin
      for (int f = 0; f < 4; f++) fr[f] = vecs[i].frame;
      run_conv($sformatf("vec%0d", i), vecs[i].ms, vecs[i].div, 1'b0, vecs[i].exp_res);
    end

    // Starts while busy and a clk_div change mid-SHIFT are ignored.
    for (int f = 0; f < 4; f++) fr[f] = 16'h14B8;
    run_conv("ignore_start", 4'h3, 3'd1, 1'b1, 12'hA5C);

    // Reset asserted in the middle of SHIFT.
    for (int f = 0; f < 4; f++) fr[f] = 16'h0FFE;
    mux_sel = 4'h7; clk_div = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (MUX_SETTLE + 3 + 7) @(negedge clk);
    chk("rst_pre_cs_low", int'(adc_cs), 0);
    rst = 1'b0;
    #1;
    chk("rst_cs", int'(adc_cs), 1);
    chk("rst_sclk", int'(adc_clock), 1);
    chk("rst_mux_en", int'(adc_mux_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mux_s", int'(adc_mux_s), 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rst_no_done", dn, 0);
    run_conv("after_rst", 4'h7, 3'd2, 1'b0, 12'h7FF);

`ifdef BP_ADC_AVERAGE_EN
    fr[0] = 16'h0200; fr[1] = 16'h0202; fr[2] = 16'h0204; fr[3] = 16'h0206;
    run_conv("average", 4'h3, 3'd0, 1'b0, 12'h101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
